// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Round-robin N-master to 1-slave arbiter for a memory handshake.
// Revision : 1.0  initial release
// ============================================================================
module memory_arbiter #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int NUMBER_OF_MASTERS = 4
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUMBER_OF_MASTERS*ADDRESS_WIDTH-1:0] masterAddress,
    input  logic [NUMBER_OF_MASTERS*DATA_WIDTH-1:0]    masterDataOut,
    input  logic [NUMBER_OF_MASTERS-1:0]               masterWriteEnabled,
    input  logic [NUMBER_OF_MASTERS-1:0]               masterReadEnabled,
    output logic [NUMBER_OF_MASTERS*DATA_WIDTH-1:0]    masterDataIn,
    output logic [NUMBER_OF_MASTERS-1:0]               masterFunctionComplete,
    output logic [ADDRESS_WIDTH-1:0]                   slaveAddress,
    output logic [DATA_WIDTH-1:0]                      slaveDataOut,
    output logic                                       slaveWriteEnabled,
    output logic                                       slaveReadEnabled,
    input  logic [DATA_WIDTH-1:0]                      slaveDataIn,
    input  logic                                       slaveFunctionComplete,
    output logic                                       grantValid,
    output logic [$clog2(NUMBER_OF_MASTERS)-1:0]       grantIndex
);

    localparam int GW = $clog2(NUMBER_OF_MASTERS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [GW-1:0]          r_grantIndex;
    logic [GW-1:0]          r_lastGrant;
    logic [GW-1:0]          w_pick;
    logic                   w_found;
    logic [NUMBER_OF_MASTERS-1:0] w_req;

    assign w_req = masterWriteEnabled | masterReadEnabled;

    // Scan starts just past the previous owner so every master gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUMBER_OF_MASTERS; k++) begin
            int idx;
            idx = (int'(r_lastGrant) + k) % NUMBER_OF_MASTERS;
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = S_GRANTED;
            S_GRANTED: if (slaveFunctionComplete || !w_req[r_grantIndex]) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grantIndex <= '0;
            r_lastGrant  <= GW'(NUMBER_OF_MASTERS - 1);
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_grantIndex <= w_pick;
                r_lastGrant  <= w_pick;
            end
        end
    end

    // Datapath is live only while a grant is held; everything else reads zero.
    always_comb begin
        slaveAddress           = '0;
        slaveDataOut           = '0;
        slaveWriteEnabled      = 1'b0;
        slaveReadEnabled       = 1'b0;
        masterDataIn           = '0;
        masterFunctionComplete = '0;
        if (r_state == S_GRANTED) begin
            slaveAddress      = masterAddress[r_grantIndex*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            slaveDataOut      = masterDataOut[r_grantIndex*DATA_WIDTH +: DATA_WIDTH];
            slaveWriteEnabled = masterWriteEnabled[r_grantIndex];
            slaveReadEnabled  = masterReadEnabled[r_grantIndex] & ~masterWriteEnabled[r_grantIndex];
            masterDataIn[r_grantIndex*DATA_WIDTH +: DATA_WIDTH] = slaveDataIn;
            masterFunctionComplete[r_grantIndex]                = slaveFunctionComplete;
        end
    end

    assign grantValid = (r_state == S_GRANTED);
    assign grantIndex = r_grantIndex;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Purpose  : Directed self-checking bench for memory_arbiter (N=4, 32-bit).
// Revision : 1.0  initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*AW-1:0] masterAddress;
    logic [N*DW-1:0] masterDataOut;
    logic [N-1:0]    masterWriteEnabled;
    logic [N-1:0]    masterReadEnabled;
    logic [N*DW-1:0] masterDataIn;
    logic [N-1:0]    masterFunctionComplete;
    logic [AW-1:0]   slaveAddress;
    logic [DW-1:0]   slaveDataOut;
    logic            slaveWriteEnabled;
    logic            slaveReadEnabled;
    logic [DW-1:0]   slaveDataIn;
    logic            slaveFunctionComplete;
    logic            grantValid;
    logic [1:0]      grantIndex;

    int checks   = 0;
    int failures = 0;

    memory_arbiter #(
        .ADDRESS_WIDTH     (AW),
        .DATA_WIDTH        (DW),
        .NUMBER_OF_MASTERS (N)
    ) u_dut (
        .clock                  (clock),
        .reset                  (reset),
        .masterAddress          (masterAddress),
        .masterDataOut          (masterDataOut),
        .masterWriteEnabled     (masterWriteEnabled),
        .masterReadEnabled      (masterReadEnabled),
        .masterDataIn           (masterDataIn),
        .masterFunctionComplete (masterFunctionComplete),
        .slaveAddress           (slaveAddress),
        .slaveDataOut           (slaveDataOut),
        .slaveWriteEnabled      (slaveWriteEnabled),
        .slaveReadEnabled       (slaveReadEnabled),
        .slaveDataIn            (slaveDataIn),
        .slaveFunctionComplete  (slaveFunctionComplete),
        .grantValid             (grantValid),
        .grantIndex             (grantIndex)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Grant expected on the next edge, complete it, then walk RELEASE and IDLE.
    task automatic serve(input int exp_idx);
        tick();
        check("rr_valid", grantValid, 1);
        check("rr_index", grantIndex, exp_idx);
        check("rr_addr", slaveAddress, 32'h10 * exp_idx);
        check("rr_re", slaveReadEnabled, 1);
        slaveFunctionComplete = 1'b1;
        slaveDataIn           = 32'hA000 + exp_idx;
        #1;
        check("rr_fc", masterFunctionComplete, 4'b1 << exp_idx);
        tick();
        slaveFunctionComplete = 1'b0;
        check("rr_rel_valid", grantValid, 0);
        check("rr_rel_re", slaveReadEnabled, 0);
        tick();
        check("rr_idle_re", slaveReadEnabled, 0);
    endtask

    initial begin
        reset = 1'b1;
        masterAddress = '0;
        masterDataOut = '0;
        masterWriteEnabled = '0;
        masterReadEnabled = '0;
        slaveDataIn = '0;
        slaveFunctionComplete = 1'b0;
        tick();
        tick();
        check("rst_valid", grantValid, 0);
        check("rst_index", grantIndex, 0);
        check("rst_we", slaveWriteEnabled, 0);
        check("rst_re", slaveReadEnabled, 0);
        check("rst_fc", masterFunctionComplete, 0);
        reset = 1'b0;

        // Single read by master 2, slave answers after three cycles.
        masterAddress[2*AW +: AW] = 32'h100;
        masterReadEnabled[2] = 1'b1;
        tick();
        check("rd_valid", grantValid, 1);
        check("rd_index", grantIndex, 2);
        check("rd_addr", slaveAddress, 32'h100);
        check("rd_re", slaveReadEnabled, 1);
        tick();
        tick();
        check("rd_wait_fc", masterFunctionComplete, 0);
        slaveFunctionComplete = 1'b1;
        slaveDataIn = 32'hDEADBEEF;
        #1;
        check("rd_data", masterDataIn[2*DW +: DW], 32'hDEADBEEF);
        check("rd_fc", masterFunctionComplete, 4'b0100);
        check("rd_other_data", masterDataIn[0 +: DW], 0);
        masterReadEnabled[2] = 1'b0;
        tick();
        slaveFunctionComplete = 1'b0;
        check("rd_rel_valid", grantValid, 0);
        check("rd_rel_fc", masterFunctionComplete, 0);
        check("rd_rel_addr", slaveAddress, 0);
        tick();

        // Round-robin from reset with all masters requesting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) masterAddress[i*AW +: AW] = 32'h10 * i;
        masterReadEnabled = 4'b1111;
        for (int g = 0; g < 8; g++) serve(g % N);

        // Gapped requests after master 3: expect 1, 3, 1.
        masterReadEnabled = 4'b1010;
        serve(1);
        serve(3);
        serve(1);
        masterReadEnabled = 4'b0000;

        // Read+write conflict on master 0: write wins.
        masterWriteEnabled[0] = 1'b1;
        masterReadEnabled[0]  = 1'b1;
        masterDataOut[0 +: DW] = 32'h55;
        tick();
        check("rw_index", grantIndex, 0);
        check("rw_we", slaveWriteEnabled, 1);
        check("rw_re", slaveReadEnabled, 0);
        check("rw_data", slaveDataOut, 32'h55);
        slaveFunctionComplete = 1'b1;
        masterWriteEnabled[0] = 1'b0;
        masterReadEnabled[0]  = 1'b0;
        tick();
        slaveFunctionComplete = 1'b0;
        tick();

        // Abort: master 2 drops before completion, master 3 waits.
        masterReadEnabled = 4'b1100;
        tick();
        check("ab_index", grantIndex, 2);
        masterReadEnabled[2] = 1'b0;
        tick();
        check("ab_rel_valid", grantValid, 0);
        slaveFunctionComplete = 1'b1;
        slaveDataIn = 32'h1234;
        #1;
        check("ab_late_fc", masterFunctionComplete, 0);
        check("ab_late_data", masterDataIn, 0);
        tick();
        check("ab_idle_fc", masterFunctionComplete, 0);
        check("ab_idle_valid", grantValid, 0);
        slaveFunctionComplete = 1'b0;
        tick();
        check("ab_next_valid", grantValid, 1);
        check("ab_next_index", grantIndex, 3);
        slaveFunctionComplete = 1'b1;
        masterReadEnabled = 4'b0000;
        tick();
        slaveFunctionComplete = 1'b0;
        tick();

        // Reset while master 1 holds the grant.
        masterReadEnabled = 4'b0010;
        tick();
        check("mr_index", grantIndex, 1);
        check("mr_valid", grantValid, 1);
        reset = 1'b1;
        masterReadEnabled = 4'b1111;
        tick();
        reset = 1'b0;
        check("mr_valid_after", grantValid, 0);
        check("mr_re_after", slaveReadEnabled, 0);
        check("mr_we_after", slaveWriteEnabled, 0);
        check("mr_fc_after", masterFunctionComplete, 0);
        tick();
        check("mr_first_valid", grantValid, 1);
        check("mr_first_index", grantIndex, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised N-master to 1-slave arbiter for the memory handshake (address, dataOut, writeEnabled, readEnabled toward memory; dataIn, functionComplete back). It sits between several memory masters (cache controllers, DMA, bus units) and a single memory slave. It grants one master at a time in round-robin order and routes that master's transaction to the slave and the slave's response back to it. Each transaction is held until the slave reports completion.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- NUMBER_OF_MASTERS, 4, master channel count N (N ≥ 2); grant index width GW = $clog2(N)

Ports (master i occupies slice [i*W +: W] of each flattened vector). One clock; reset is synchronous and active-high.
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- masterAddress  in  N*ADDRESS_WIDTH  per-master address
- masterDataOut  in  N*DATA_WIDTH  per-master write data
- masterWriteEnabled  in  N  per-master write request
- masterReadEnabled  in  N  per-master read request
- masterDataIn  out  N*DATA_WIDTH  per-master read data
- masterFunctionComplete  out  N  per-master completion strobe
- slaveAddress  out  ADDRESS_WIDTH  address to memory
- slaveDataOut  out  DATA_WIDTH  write data to memory
- slaveWriteEnabled  out  1  write request to memory
- slaveReadEnabled  out  1  read request to memory
- slaveDataIn  in  DATA_WIDTH  read data from memory
- slaveFunctionComplete  in  1  completion from memory
- grantValid  out  1  a master currently owns the slave
- grantIndex  out  GW  index of the owning master

## Operation
- Request of master i: req[i] = masterWriteEnabled[i] | masterReadEnabled[i]. If both are high, write is forwarded and read is suppressed.
- State machine states:
  - IDLE: no grant, slave enables low. If any req is high, pick the first requesting index scanning lastGrant+1, lastGrant+2, … mod N. Register grantIndex, set lastGrant to that index, go to GRANTED.
  - GRANTED: slaveAddress, slaveDataOut and enables are muxed combinationally from master grantIndex. slaveDataIn and slaveFunctionComplete route only to master grantIndex.
    - slaveFunctionComplete = 1: go to RELEASE.
    - Granted master's req drops before completion (abort): go to RELEASE.
  - RELEASE: one cycle, slave enables forced low, then IDLE. This guarantees the slave sees the enables drop between transactions.
- Non-granted masters see masterFunctionComplete = 0 and masterDataIn = 0.
- In IDLE and RELEASE: all masterFunctionComplete = 0, all masterDataIn = 0, slaveAddress and slaveDataOut = 0.
- Requests from non-granted masters wait; no request is dropped or reordered within a master.

## Timing
- Reset (synchronous): state = IDLE, lastGrant = N-1 (master 0 has top priority after reset), grantValid = 0, grantIndex = 0.
  - Slave enables and all master outputs are 0 from the cycle after reset is sampled high.
  - Reset mid-transaction aborts it silently; no completion is delivered.
- grantValid = 1 exactly in GRANTED.
- Latency: request sampled in IDLE at edge k; slave sees it in cycle k+1.
- slaveFunctionComplete passes combinationally to the granted master in the same cycle (zero added latency on the response path).
- Back-to-back turnaround: complete at cycle c → RELEASE at c+1 → IDLE at c+2 → next grant visible at c+3. Minimum 3 cycles of arbiter overhead per transaction beyond slave latency.
- slaveFunctionComplete arriving in IDLE or RELEASE is ignored.
- Wrap-around: lastGrant = N-1 scans from 0.
- A single requester is re-granted after every RELEASE (no starvation of a lone master).

## Test plan
- Single read, N=4: master 2 reads 0x100, slave completes after 3 cycles with 0xDEADBEEF.
  - Expected: slaveAddress = 0x100 one cycle after request.
  - Expected: masterDataIn[2] = 0xDEADBEEF with masterFunctionComplete[2] = 1 for one cycle.
  - Expected: other completes stay 0.
- Round-robin: masters 0–3 all request continuously from reset.
  - Expected grant order: 0,1,2,3,0,…
  - Expected: each grant preceded by IDLE/RELEASE, so slave enables are low for ≥2 cycles between grants.
- Wrap with gaps: after master 3 is served, only masters 1 and 3 request.
  - Expected: 1 granted next, then 3, then 1.
- Read+write conflict: master 0 asserts both enables, dataOut = 0x55.
  - Expected: slaveWriteEnabled = 1, slaveReadEnabled = 0, slaveDataOut = 0x55.
- Abort: granted master drops its request before completion.
  - Expected: RELEASE next cycle, then the next requester is granted.
  - Expected: a late slaveFunctionComplete during RELEASE reaches no master.
- Reset mid-transaction: assert reset while master 1 is in GRANTED.
  - Expected next cycle: grantValid = 0 and slave enables = 0.
  - Expected: with all masters requesting after reset, master 0 is granted first.
